clk_div_cfg_ctrl: RTL and testbench

//  Arbitrated, glitch-safe configuration controller for the programmable clock divider.
//  N requesters ask for a new divide factor. A round-robin arbiter picks one request at a time.

---
 rtl/clk_div_pkg.sv | 15 +
 rtl/clk_div_cfg_ctrl_rr_arbiter.sv | 31 +++
 rtl/clk_div_cfg_ctrl.sv | 155 +++++++++++++++
 tb/tb_clk_div_cfg_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock-divider configuration controller.
package clk_div_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHECK     = 3'd1,
        WAIT_EDGE = 3'd2,
        ACK       = 3'd3,
        NACK      = 3'd4
    } ctrl_state_t;

    // Smallest factor the divider can produce a clock from.
    localparam int DIV_MIN = 2;

endpackage

// File: rtl/clk_div_cfg_ctrl_rr_arbiter.sv
// Combinational round-robin grant: first requester at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic                     o_valid,
    output logic [$clog2(N_REQ)-1:0] o_grant
);

    localparam int PW = $clog2(N_REQ);

    int unsigned w_cand;

    // Scan the requesters starting at the pointer and take the first one set.
    always_comb begin
        o_valid = 1'b0;
        o_grant = '0;
        w_cand  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = (int'(i_ptr) + k) % N_REQ;
            if (!o_valid && i_req[w_cand]) begin
                o_valid = 1'b1;
                o_grant = PW'(w_cand);
            end else begin
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Arbitrated configuration controller that updates the divider factor only just after a
// falling edge of the divided clock, with a timeout when that clock is stalled.
module clk_div_cfg_ctrl
    import clk_div_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = 50,
    parameter int TIMEOUT     = 1024
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_div,
    output logic [N_REQ-1:0]         ack,
    output logic [N_REQ-1:0]         nack,
    input  logic                     div_clk_fb,
    output logic [WIDTH-1:0]         div_value,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     timeout_flag
);

    localparam int PW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    ctrl_state_t      r_state;
    ctrl_state_t      w_state_nx;
    logic             r_fb_q;
    logic [TW-1:0]    r_timer;
    logic [WIDTH-1:0] r_val;
    logic [WIDTH-1:0] r_div;
    logic [PW-1:0]    r_owner;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    w_ptr_nx;
    logic [N_REQ-1:0] r_ack;
    logic [N_REQ-1:0] r_nack;
    logic             r_busy;
    logic             r_tmo;

    logic             w_fall;
    logic             w_tmo_hit;
    logic             w_arb_valid;
    logic [PW-1:0]    w_grant;
    logic             w_take;
    logic             w_apply;
    logic             w_tmo_set;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_valid (w_arb_valid),
        .o_grant (w_grant)
    );

    assign w_fall    = r_fb_q & ~div_clk_fb;
    assign w_tmo_hit = (r_timer == TW'(TIMEOUT - 1));
    assign w_ptr_nx  = (r_owner == PW'(N_REQ - 1)) ? '0 : r_owner + PW'(1);

    // Next-state decode and the one-cycle action strobes that go with each transition.
    always_comb begin
        w_state_nx = r_state;
        w_take     = 1'b0;
        w_apply    = 1'b0;
        w_tmo_set  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_take     = 1'b1;
                    w_state_nx = CHECK;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            CHECK: begin
                if (r_val < WIDTH'(DIV_MIN)) begin
                    w_state_nx = NACK;
                end else if (r_val == r_div) begin
                    w_state_nx = ACK;
                end else begin
                    w_state_nx = WAIT_EDGE;
                end
            end
            WAIT_EDGE: begin
                // A real edge wins over the timeout when both land in the same cycle.
                if (w_fall) begin
                    w_apply    = 1'b1;
                    w_state_nx = ACK;
                end else if (w_tmo_hit) begin
                    w_apply    = 1'b1;
                    w_tmo_set  = 1'b1;
                    w_state_nx = ACK;
                end else begin
                    w_state_nx = WAIT_EDGE;
                end
            end
            ACK:     w_state_nx = IDLE;
            NACK:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // State, feedback sample, timer, latched request and all registered outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_fb_q  <= 1'b0;
            r_timer <= '0;
            r_val   <= '0;
            r_div   <= WIDTH'(DEFAULT_DIV);
            r_owner <= '0;
            r_ptr   <= '0;
            r_ack   <= '0;
            r_nack  <= '0;
            r_busy  <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_fb_q  <= div_clk_fb;
            r_busy  <= (w_state_nx != IDLE);
            r_ack   <= '0;
            r_nack  <= '0;
            if (w_take) begin
                r_owner <= w_grant;
                r_val   <= req_div[int'(w_grant)*WIDTH +: WIDTH];
            end
            if (r_state == CHECK) begin
                r_timer <= '0;
            end else if (r_state == WAIT_EDGE) begin
                r_timer <= r_timer + TW'(1);
            end
            if (w_apply) begin
                r_div <= r_val;
            end
            if (w_tmo_set) begin
                r_tmo <= 1'b1;
            end
            if (r_state == ACK) begin
                r_ack[r_owner] <= 1'b1;
                r_ptr          <= w_ptr_nx;
            end else if (r_state == NACK) begin
                r_nack[r_owner] <= 1'b1;
                r_ptr           <= w_ptr_nx;
            end
        end
    end

    assign ack          = r_ack;
    assign nack         = r_nack;
    assign div_value    = r_div;
    assign busy         = r_busy;
    assign owner        = r_owner;
    assign timeout_flag = r_tmo;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Self-checking bench: directed divider scenarios, a vector table and a randomized run
// against a round-robin reference model.
module tb_clk_div_cfg_ctrl;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [127:0] req_div;
    logic [3:0]   ack;
    logic [3:0]   nack;
    logic [31:0]  div_value;
    logic         busy;
    logic [1:0]   owner;
    logic         tflag;

    logic         div_rst;
    logic         clk_out;
    logic [31:0]  dcnt;
    int           cyc;

    int n_cmp = 0;
    int n_err = 0;

    clk_div_cfg_ctrl dut (
        .clk_in       (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_div      (req_div),
        .ack          (ack),
        .nack         (nack),
        .div_clk_fb   (clk_out),
        .div_value    (div_value),
        .busy         (busy),
        .owner        (owner),
        .timeout_flag (tflag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural divider: each half-period lasts div_value/2 input cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_out <= 1'b0;
            dcnt    <= 32'd0;
        end else if (div_rst) begin
            clk_out <= 1'b0;
            dcnt    <= 32'd0;
        end else if (dcnt >= (div_value >> 1) - 32'd1) begin
            clk_out <= ~clk_out;
            dcnt    <= 32'd0;
        end else begin
            dcnt <= dcnt + 32'd1;
        end
    end

    typedef struct {
        int          idx;
        logic [31:0] fac;
        bit          exp_ack;
        logic [31:0] exp_div;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic wait_rise(output int at);
        logic prev;
        prev = clk_out;
        at = -1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (!prev && clk_out) begin
                at = cyc;
                break;
            end
            prev = clk_out;
        end
    endtask

    // Raise one request and wait for its pulse; lat counts clock edges from the first edge.
    task automatic serve(input int idx, input logic [31:0] fac, input int bound,
                         output int kind, output int who, output int lat);
        req_div[idx*32 +: 32] = fac;
        req[idx] = 1'b1;
        kind = -1; who = -1; lat = -1;
        for (int i = 0; i < bound; i++) begin
            step();
            if ((ack | nack) != 4'd0) begin
                kind = (ack != 4'd0) ? 1 : 0;
                who  = oh_idx(ack | nack);
                lat  = i;
                req[idx] = 1'b0;
                break;
            end
        end
        req[idx] = 1'b0;
    endtask

    initial begin
        int t1, t2, last, fall_c, dchg, ack_c, ack_n, kind, who, lat;
        logic prev_c;
        logic [31:0] prev_d;
        int order[4];
        int n_ack;
        int mptr;
        logic [31:0] mdiv;
        logic [3:0] pend;
        logic [31:0] fac[4];

        rst_n = 1'b0; req = 4'd0; req_div = '0; div_rst = 1'b0;
        vecs[0] = '{3, 32'd0,  1'b0, 32'd12, 2};
        vecs[1] = '{1, 32'd12, 1'b1, 32'd12, 2};
        vecs[2] = '{0, 32'd3,  1'b1, 32'd3, -1};
        vecs[3] = '{2, 32'd2,  1'b1, 32'd2, -1};
        vecs[4] = '{1, 32'd1,  1'b0, 32'd2,  2};
        vecs[5] = '{3, 32'd9,  1'b1, 32'd9, -1};

        // 1. reset values and default period
        step(); step(); step();
        check("rst_div", div_value, 32'd50);
        check("rst_busy", busy, 1'b0);
        check("rst_ack", ack, 4'd0);
        check("rst_nack", nack, 4'd0);
        check("rst_owner", owner, 2'd0);
        check("rst_tflag", tflag, 1'b0);
        rst_n = 1'b1;
        wait_rise(t1);
        wait_rise(t2);
        check("period_default", t2 - t1, 50);

        // 2. req[1]=10, applied at the first fall with clean half-periods
        req_div[32 +: 32] = 32'd10;
        req = 4'b0010;
        prev_c = clk_out; last = t2; fall_c = -1; dchg = -1; ack_c = -1; ack_n = 0;
        prev_d = div_value;
        for (int i = 0; i < 120; i++) begin
            step();
            if (ack[1]) begin
                ack_n++;
                if (ack_c < 0) ack_c = cyc;
                req = 4'd0;
            end
            if (div_value !== prev_d && dchg < 0) dchg = cyc;
            if (clk_out !== prev_c) begin
                if (!clk_out && fall_c < 0) fall_c = cyc;
                check("half_period", cyc - last, (fall_c >= 0 && last >= fall_c) ? 5 : 25);
                last = cyc;
                prev_c = clk_out;
            end
            prev_d = div_value;
        end
        check("t2_div_change", dchg, fall_c + 1);
        check("t2_ack_time", ack_c, fall_c + 2);
        check("t2_ack_count", ack_n, 1);
        check("t2_div", div_value, 32'd10);

        // 3. all four requesters from pointer 0 are served in order
        do_reset();
        req_div = {32'd12, 32'd8, 32'd6, 32'd4};
        req = 4'b1111;
        n_ack = 0;
        for (int i = 0; i < 1000 && n_ack < 4; i++) begin
            step();
            if (nack != 4'd0) check("t3_nack", nack, 4'd0);
            if (ack != 4'd0) begin
                order[n_ack] = oh_idx(ack);
                req[oh_idx(ack)] = 1'b0;
                n_ack++;
            end
        end
        check("t3_count", n_ack, 4);
        for (int k = 0; k < 4; k++) check("t3_order", (k < n_ack) ? order[k] : -1, k);
        check("t3_div", div_value, 32'd12);

        // 4. factor 1 is rejected two edges after the grant
        serve(2, 32'd1, 50, kind, who, lat);
        check("t4_kind_nack", kind, 0);
        check("t4_who", who, 2);
        check("t4_lat", lat, 2);
        check("t4_div", div_value, 32'd12);
        check("t4_tflag", tflag, 1'b0);

        // Vector table: rejections, no-ops and applied odd/minimum factors.
        for (int v = 0; v < 6; v++) begin
            serve(vecs[v].idx, vecs[v].fac, 300, kind, who, lat);
            check("vec_kind", kind, vecs[v].exp_ack ? 1 : 0);
            check("vec_who", who, vecs[v].idx);
            check("vec_div", div_value, vecs[v].exp_div);
            if (vecs[v].exp_lat >= 0) check("vec_lat", lat, vecs[v].exp_lat);
        end

        // Randomized rounds against a round-robin model; the last table entry leaves pointer 0.
        mptr = 0;
        mdiv = 32'd9;
        for (int r = 0; r < 20; r++) begin
            pend = 4'($urandom_range(1, 15));
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 9))
                    0:       fac[k] = 32'd0;
                    1:       fac[k] = 32'd1;
                    2:       fac[k] = mdiv;
                    default: fac[k] = 32'($urandom_range(2, 20));
                endcase
                req_div[k*32 +: 32] = fac[k];
            end
            req = pend;
            for (int t = 0; t < 4 && pend != 4'd0; t++) begin
                int g;
                bit got;
                g = -1;
                for (int j = 0; j < 4; j++)
                    if (g < 0 && pend[(mptr + j) % 4]) g = (mptr + j) % 4;
                got = 1'b0;
                for (int i = 0; i < 300; i++) begin
                    step();
                    if ((ack | nack) != 4'd0) begin
                        got = 1'b1;
                        break;
                    end
                end
                check("rnd_pulse_seen", got, 1'b1);
                if (fac[g] >= 32'd2) mdiv = fac[g];
                check("rnd_who", oh_idx(ack | nack), g);
                check("rnd_kind", (ack != 4'd0) ? 1 : 0, (fac[g] >= 32'd2) ? 1 : 0);
                check("rnd_div", div_value, mdiv);
                pend[g] = 1'b0;
                req = pend;
                mptr = (g + 1) % 4;
            end
            req = 4'd0;
        end
        check("rnd_tflag", tflag, 1'b0);

        // 5. stalled divider: forced update after TIMEOUT cycles in WAIT_EDGE
        div_rst = 1'b1;
        step(); step(); step();
        req_div[31:0] = 32'd20;
        req = 4'b0001;
        dchg = -1; ack_c = -1;
        for (int i = 0; i < 1200; i++) begin
            step();
            if (div_value == 32'd20 && dchg < 0) dchg = i;
            if (ack[0]) begin
                ack_c = i;
                req = 4'd0;
                break;
            end
        end
        req = 4'd0;
        check("t5_div_time", dchg, 1025);
        check("t5_ack_time", ack_c, 1026);
        check("t5_div", div_value, 32'd20);
        check("t5_tflag", tflag, 1'b1);

        // 6. reset in WAIT_EDGE drops the transaction, then a fresh request completes
        req_div[63:32] = 32'd30;
        req = 4'b0010;
        for (int i = 0; i < 10; i++) step();
        check("t6_busy_wait", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_div", div_value, 32'd50);
        check("t6_rst_tflag", tflag, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        ack_n = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ack != 4'd0) ack_n++;
        end
        req = 4'd0;
        rst_n = 1'b1;
        div_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ack != 4'd0) ack_n++;
        end
        check("t6_no_ack", ack_n, 0);
        serve(3, 32'd6, 300, kind, who, lat);
        check("t6_kind", kind, 1);
        check("t6_who", who, 3);
        check("t6_div", div_value, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
